// File: rtl/prim_secded_inv_39_32_dec_pipe.sv
// Elastic multi-lane inverted Hsiao (39,32) SECDED decoder.
// Corrects single-bit errors, flags doubles, keeps saturating error counters.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o input handshake, in_cw_i lane k at [39k+38:39k]
//   out_valid_o/out_ready_i output handshake
//   out_data_o            corrected data, 32 bits per lane
//   out_syndrome_o        syndrome, 7 bits per lane
//   out_err_o             per lane {double, single}
//   cnt_clr_i             clears counters and the sticky alert
//   cnt_single_o/cnt_double_o saturating per-lane error counts
//   dbl_alert_o           sticky double-error alert
module prim_secded_inv_39_32_dec_pipe #(
  parameter int unsigned NumLanes  = 1,
  parameter int unsigned NumStages = 2,
  parameter bit          CorrectEn = 1'b1,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NumLanes*39-1:0]  in_cw_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NumLanes*32-1:0]  out_data_o,
  output logic [NumLanes*7-1:0]   out_syndrome_o,
  output logic [NumLanes*2-1:0]   out_err_o,
  input  logic                    cnt_clr_i,
  output logic [CntWidth-1:0]     cnt_single_o,
  output logic [CntWidth-1:0]     cnt_double_o,
  output logic                    dbl_alert_o
);

  localparam logic [38:0] InvMask = 39'h2A00000000;

  localparam logic [6:0][31:0] Masks = {
    32'h98505586, 32'h2DCC624C, 32'hC2C1323B,
    32'h31234ED1, 32'h413D89AA, 32'hDEBA8050,
    32'h2606BD25
  };

  localparam int unsigned SumW = CntWidth + 4;
  localparam logic [SumW-1:0] CntMax =
    SumW'({CntWidth{1'b1}});

  function automatic logic [6:0] syn_f(
    input logic [38:0] c
  );
    logic [6:0] s;
    for (int i = 0; i < 7; i++) begin
      s[i] = ^(c[31:0] & Masks[i]) ^ c[32+i];
    end
    return s;
  endfunction

  // Flip data bit j only when the syndrome equals its column;
  // check-bit and double errors never match a data column.
  function automatic logic [31:0] fix_f(
    input logic [31:0] d,
    input logic [6:0]  s
  );
    logic [31:0] f;
    logic [6:0]  col;
    f = d;
    for (int j = 0; j < 32; j++) begin
      for (int i = 0; i < 7; i++) begin
        col[i] = Masks[i][j];
      end
      if (CorrectEn && s == col) begin
        f[j] = ~d[j];
      end
    end
    return f;
  endfunction

  function automatic logic [1:0] err_f(
    input logic [6:0] s
  );
    return {(s != '0) & ~^s, (s != '0) & ^s};
  endfunction

  logic [NumLanes*39-1:0] in_c;
  logic [NumLanes*32-1:0] in_data;
  logic [NumLanes*7-1:0]  in_syn;

  assign in_c = in_cw_i ^ {NumLanes{InvMask}};

  always_comb begin
    in_data = '0;
    in_syn  = '0;
    for (int k = 0; k < NumLanes; k++) begin
      in_data[32*k +: 32] = in_c[39*k +: 32];
      in_syn[7*k +: 7]    = syn_f(in_c[39*k +: 39]);
    end
  end

  logic                   q_valid;
  logic [NumLanes*32-1:0] q_data;
  logic [NumLanes*7-1:0]  q_syn;
  logic [NumLanes*2-1:0]  q_err;
  logic                   q_load;
  logic                   out_hs;
  logic                   s0_valid;
  logic                   s0_adv;
  logic [NumLanes*32-1:0] src_data;
  logic [NumLanes*7-1:0]  src_syn;

  assign out_hs     = q_valid & out_ready_i;
  assign in_ready_o = ~s0_valid | s0_adv;

  if (NumStages == 1) begin : g_one
    assign s0_valid = q_valid;
    assign s0_adv   = out_hs;
    assign q_load   = in_valid_i & in_ready_o;
    assign src_data = in_data;
    assign src_syn  = in_syn;
  end else begin : g_two
    logic                   p_valid;
    logic [NumLanes*32-1:0] p_data;
    logic [NumLanes*7-1:0]  p_syn;
    logic                   p_load;

    assign p_load   = in_valid_i & in_ready_o;
    assign s0_valid = p_valid;
    assign s0_adv   = p_valid & (~q_valid | out_hs);
    assign q_load   = s0_adv;
    assign src_data = p_data;
    assign src_syn  = p_syn;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        p_valid <= 1'b0;
      end else if (p_load) begin
        p_valid <= 1'b1;
      end else if (s0_adv) begin
        p_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (p_load) begin
        p_data <= in_data;
        p_syn  <= in_syn;
      end
    end
  end

  logic [NumLanes*32-1:0] nxt_data;
  logic [NumLanes*2-1:0]  nxt_err;

  always_comb begin
    nxt_data = '0;
    nxt_err  = '0;
    for (int k = 0; k < NumLanes; k++) begin
      nxt_data[32*k +: 32] =
        fix_f(src_data[32*k +: 32], src_syn[7*k +: 7]);
      nxt_err[2*k +: 2] = err_f(src_syn[7*k +: 7]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_valid <= 1'b0;
    end else if (q_load) begin
      q_valid <= 1'b1;
    end else if (out_hs) begin
      q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (q_load) begin
      q_data <= nxt_data;
      q_syn  <= src_syn;
      q_err  <= nxt_err;
    end
  end

  assign out_valid_o    = q_valid;
  assign out_data_o     = q_valid ? q_data : '0;
  assign out_syndrome_o = q_valid ? q_syn  : '0;
  assign out_err_o      = q_valid ? q_err  : '0;

  logic [3:0]          pop_s;
  logic [3:0]          pop_d;
  logic [SumW-1:0]     sum_s;
  logic [SumW-1:0]     sum_d;
  logic [CntWidth-1:0] cnt_s_q;
  logic [CntWidth-1:0] cnt_d_q;
  logic                alert_q;

  always_comb begin
    pop_s = '0;
    pop_d = '0;
    for (int k = 0; k < NumLanes; k++) begin
      pop_s = pop_s + 4'(q_err[2*k]);
      pop_d = pop_d + 4'(q_err[2*k+1]);
    end
  end

  assign sum_s = SumW'(cnt_s_q) + SumW'(pop_s);
  assign sum_d = SumW'(cnt_d_q) + SumW'(pop_d);

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      cnt_s_q <= '0;
      cnt_d_q <= '0;
      alert_q <= 1'b0;
    end else if (out_hs) begin
      cnt_s_q <= (sum_s > CntMax) ? '1
                 : sum_s[CntWidth-1:0];
      cnt_d_q <= (sum_d > CntMax) ? '1
                 : sum_d[CntWidth-1:0];
      if (pop_d != '0) begin
        alert_q <= 1'b1;
      end
    end
  end

  assign cnt_single_o = cnt_s_q;
  assign cnt_double_o = cnt_d_q;
  assign dbl_alert_o  = alert_q;

endmodule

// File: tb/tb_prim_secded_inv_39_32_dec_pipe.sv
// Directed bench for the SECDED decoder pipeline.
// Three instances: default, detect-only, and 2-lane/1-stage/2-bit counters.
module tb_prim_secded_inv_39_32_dec_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [38:0] in_cw_a;
  logic [31:0] out_data_a;
  logic [6:0]  out_syn_a;
  logic [1:0]  out_err_a;
  logic        clr_a, alert_a;
  logic [15:0] cnt_s_a, cnt_d_a;

  // Instance B: detect only
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [38:0] in_cw_b;
  logic [31:0] out_data_b;
  logic [6:0]  out_syn_b;
  logic [1:0]  out_err_b;
  logic        clr_b, alert_b;
  logic [15:0] cnt_s_b, cnt_d_b;

  // Instance C: 2 lanes, 1 stage, 2-bit counters
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [77:0] in_cw_c;
  logic [63:0] out_data_c;
  logic [13:0] out_syn_c;
  logic [3:0]  out_err_c;
  logic        clr_c, alert_c;
  logic [1:0]  cnt_s_c, cnt_d_c;

  prim_secded_inv_39_32_dec_pipe dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
    .in_cw_i(in_cw_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
    .out_data_o(out_data_a), .out_syndrome_o(out_syn_a),
    .out_err_o(out_err_a), .cnt_clr_i(clr_a),
    .cnt_single_o(cnt_s_a), .cnt_double_o(cnt_d_a),
    .dbl_alert_o(alert_a)
  );

  prim_secded_inv_39_32_dec_pipe #(.CorrectEn(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .in_cw_i(in_cw_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
    .out_data_o(out_data_b), .out_syndrome_o(out_syn_b),
    .out_err_o(out_err_b), .cnt_clr_i(clr_b),
    .cnt_single_o(cnt_s_b), .cnt_double_o(cnt_d_b),
    .dbl_alert_o(alert_b)
  );

  prim_secded_inv_39_32_dec_pipe #(
    .NumLanes(2), .NumStages(1), .CntWidth(2)
  ) dut_c (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid_c), .in_ready_o(in_ready_c),
    .in_cw_i(in_cw_c),
    .out_valid_o(out_valid_c), .out_ready_i(out_ready_c),
    .out_data_o(out_data_c), .out_syndrome_o(out_syn_c),
    .out_err_o(out_err_c), .cnt_clr_i(clr_c),
    .cnt_single_o(cnt_s_c), .cnt_double_o(cnt_d_c),
    .dbl_alert_o(alert_c)
  );

  // Send one codeword to instance A (inst=0) or B (inst=1) and
  // wait, bounded, for its result.
  task automatic xfer(
    input  int          inst,
    input  logic [38:0] cw,
    output int          lat,
    output logic [31:0] d,
    output logic [6:0]  s,
    output logic [1:0]  e
  );
    @(posedge clk); #1;
    if (inst == 0) begin in_valid_a = 1; in_cw_a = cw; end
    else begin in_valid_b = 1; in_cw_b = cw; end
    @(posedge clk); #1;
    in_valid_a = 0;
    in_valid_b = 0;
    lat = 1;
    while (!(inst == 0 ? out_valid_a : out_valid_b)
           && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = (inst == 0) ? out_data_a : out_data_b;
    s = (inst == 0) ? out_syn_a  : out_syn_b;
    e = (inst == 0) ? out_err_a  : out_err_b;
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid_a = 0; in_valid_b = 0; in_valid_c = 0;
    in_cw_a = '0; in_cw_b = '0; in_cw_c = '0;
    out_ready_a = 1; out_ready_b = 1; out_ready_c = 1;
    clr_a = 0; clr_b = 0; clr_c = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    total++;
    if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valid got=%b want=000",
               {out_valid_a, out_valid_b, out_valid_c});
    end
    total++;
    if ({cnt_s_a, cnt_d_a, alert_a, out_data_a} !== '0) begin
      bad++;
      $display("FAIL reset_state cs=%0d cd=%0d al=%b d=%h want 0",
               cnt_s_a, cnt_d_a, alert_a, out_data_a);
    end
    total++;
    if ({in_ready_a, in_ready_c} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready got=%b want=11",
               {in_ready_a, in_ready_c});
    end
  endtask

  task automatic test_clean();
    int lat; logic [31:0] d; logic [6:0] s; logic [1:0] e;
    xfer(0, 39'h2A00000000, lat, d, s, e);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL clean_latency got=%0d want=2", lat);
    end
    total++;
    if ({d, s, e} !== '0) begin
      bad++;
      $display("FAIL clean_out d=%h s=%h e=%b want 0", d, s, e);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid_a, cnt_s_a, cnt_d_a} !== '0) begin
      bad++;
      $display("FAIL clean_after v=%b cs=%0d cd=%0d want 0",
               out_valid_a, cnt_s_a, cnt_d_a);
    end
  endtask

  task automatic test_single();
    int lat; logic [31:0] d; logic [6:0] s; logic [1:0] e;
    xfer(0, 39'h2A00000001, lat, d, s, e);
    total++;
    if ({d, s, e} !== {32'h0, 7'h19, 2'b01}) begin
      bad++;
      $display("FAIL single_out d=%h s=%h e=%b want 0/19/01",
               d, s, e);
    end
    @(posedge clk); #1;
    total++;
    if (cnt_s_a !== 16'd1) begin
      bad++; $display("FAIL single_cnt got=%0d want=1", cnt_s_a);
    end
  endtask

  task automatic test_double();
    int lat; logic [31:0] d; logic [6:0] s; logic [1:0] e;
    xfer(0, 39'h2A00000003, lat, d, s, e);
    total++;
    if ({d, s, e} !== {32'h3, 7'h4D, 2'b10}) begin
      bad++;
      $display("FAIL double_out d=%h s=%h e=%b want 3/4d/10",
               d, s, e);
    end
    @(posedge clk); #1;
    total++;
    if ({cnt_d_a, alert_a, cnt_s_a} !== {16'd1, 1'b1, 16'd1}) begin
      bad++;
      $display("FAIL double_cnt cd=%0d al=%b cs=%0d want 1/1/1",
               cnt_d_a, alert_a, cnt_s_a);
    end
  endtask

  task automatic test_checkbit();
    int lat; logic [31:0] d; logic [6:0] s; logic [1:0] e;
    xfer(0, 39'h2B00000000, lat, d, s, e);
    total++;
    if ({d, s, e} !== {32'h0, 7'h01, 2'b01}) begin
      bad++;
      $display("FAIL chkbit_out d=%h s=%h e=%b want 0/01/01",
               d, s, e);
    end
    @(posedge clk); #1;
    total++;
    if ({alert_a, cnt_s_a} !== {1'b1, 16'd2}) begin
      bad++;
      $display("FAIL chkbit_sticky al=%b cs=%0d want 1/2",
               alert_a, cnt_s_a);
    end
    xfer(1, 39'h2A00000001, lat, d, s, e);
    total++;
    if ({d, s, e} !== {32'h1, 7'h19, 2'b01}) begin
      bad++;
      $display("FAIL nocorrect d=%h s=%h e=%b want 1/19/01",
               d, s, e);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, rcv = 0, occ = 0, cyc = 0;
    logic prev_stall = 0, exp_rdy, acc, del;
    logic [31:0] prev_data = '0;
    while (rcv < 6 && cyc < 60) begin
      out_ready_a = (cyc % 3 == 0);
      in_valid_a  = (sent < 6);
      in_cw_a = 39'h2A00000000 | ({7'd0, 32'h3} << (4 * sent));
      #1;
      exp_rdy = !(occ == 2 && !out_ready_a);
      total++;
      if (in_ready_a !== exp_rdy) begin
        bad++;
        $display("FAIL bp_ready cyc=%0d got=%b want=%b",
                 cyc, in_ready_a, exp_rdy);
      end
      if (prev_stall) begin
        total++;
        if ({out_valid_a, out_data_a} !== {1'b1, prev_data}) begin
          bad++;
          $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h",
                   cyc, out_valid_a, out_data_a, prev_data);
        end
      end
      acc = in_valid_a && in_ready_a;
      del = out_valid_a && out_ready_a;
      if (del) begin
        total++;
        if ({out_data_a, out_err_a} !==
            {32'h3 << (4 * rcv), 2'b10}) begin
          bad++;
          $display("FAIL bp_data n=%0d got=%h/%b want=%h/10",
                   rcv, out_data_a, out_err_a, 32'h3 << (4 * rcv));
        end
        rcv++;
      end
      prev_stall = out_valid_a && !out_ready_a;
      prev_data  = out_data_a;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(del);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_a  = 0;
    out_ready_a = 1;
    total++;
    if (rcv !== 6) begin
      bad++; $display("FAIL bp_count got=%0d want=6", rcv);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid_a, cnt_d_a, cnt_s_a} !==
        {1'b0, 16'd7, 16'd2}) begin
      bad++;
      $display("FAIL bp_after v=%b cd=%0d cs=%0d want 0/7/2",
               out_valid_a, cnt_d_a, cnt_s_a);
    end
  endtask

  task automatic test_lanes();
    @(posedge clk); #1;
    in_valid_c = 1;
    in_cw_c = {39'h2A00000003, 39'h2A00000001};
    @(posedge clk); #1;
    in_valid_c = 0;
    total++;
    if ({out_valid_c, out_data_c, out_syn_c, out_err_c} !==
        {1'b1, 32'h3, 32'h0, 7'h4D, 7'h19, 4'b1001}) begin
      bad++;
      $display("FAIL lanes_out v=%b d=%h s=%h e=%b",
               out_valid_c, out_data_c, out_syn_c, out_err_c);
    end
    @(posedge clk); #1;
    total++;
    if ({cnt_s_c, cnt_d_c, alert_c} !== 5'b01011) begin
      bad++;
      $display("FAIL lanes_cnt cs=%0d cd=%0d al=%b want 1/1/1",
               cnt_s_c, cnt_d_c, alert_c);
    end
  endtask

  task automatic test_saturation();
    clr_c = 1;
    @(posedge clk); #1;
    clr_c = 0;
    total++;
    if ({cnt_s_c, cnt_d_c, alert_c} !== 5'b0) begin
      bad++;
      $display("FAIL clr cs=%0d cd=%0d al=%b want 0",
               cnt_s_c, cnt_d_c, alert_c);
    end
    in_cw_c = {39'h2A00000000, 39'h2A00000002};
    for (int i = 0; i < 5; i++) begin
      in_valid_c = 1;
      @(posedge clk); #1;
    end
    in_valid_c = 0;
    @(posedge clk); #1;
    total++;
    if ({cnt_s_c, cnt_d_c} !== 4'b1100) begin
      bad++;
      $display("FAIL saturate cs=%0d cd=%0d want 3/0",
               cnt_s_c, cnt_d_c);
    end
  endtask

  task automatic test_clr_handshake();
    @(posedge clk); #1;
    in_valid_c = 1;
    in_cw_c = {39'h2A00000003, 39'h2A00000000};
    @(posedge clk); #1;
    in_cw_c = {39'h2A00000003, 39'h2A00000001};
    @(posedge clk); #1;
    in_valid_c = 0;
    total++;
    if ({alert_c, cnt_s_c, out_valid_c} !== 4'b1111) begin
      bad++;
      $display("FAIL pre_clr al=%b cs=%0d v=%b want 1/3/1",
               alert_c, cnt_s_c, out_valid_c);
    end
    clr_c = 1;
    @(posedge clk); #1;
    clr_c = 0;
    total++;
    if ({cnt_s_c, cnt_d_c, alert_c, out_valid_c} !== 6'b0) begin
      bad++;
      $display("FAIL clr_hs cs=%0d cd=%0d al=%b v=%b want 0",
               cnt_s_c, cnt_d_c, alert_c, out_valid_c);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready_a = 0;
    @(posedge clk); #1;
    in_valid_a = 1;
    in_cw_a = 39'h2A00000003;
    @(posedge clk); #1;
    in_cw_a = 39'h2A0000000C;
    @(posedge clk); #1;
    in_valid_a = 0;
    total++;
    if ({out_valid_a, in_ready_a, out_data_a} !==
        {2'b10, 32'h3}) begin
      bad++;
      $display("FAIL full_stall v=%b r=%b d=%h want 1/0/3",
               out_valid_a, in_ready_a, out_data_a);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    out_ready_a = 1;
    total++;
    if ({out_valid_a, alert_a, cnt_d_a} !== '0) begin
      bad++;
      $display("FAIL rst_flight v=%b al=%b cd=%0d want 0",
               out_valid_a, alert_a, cnt_d_a);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_drop v=%b want 0", out_valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_checkbit();
    test_backpressure();
    test_lanes();
    test_saturation();
    test_clr_handshake();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
